// File: rtl/hdmi_pattern_pkg.sv
// Shared types and colour constants for the HDMI test-pattern source.
// Pattern codes match the pattern_sel encoding driven by the top level.
package hdmi_pattern_pkg;

    typedef enum logic [1:0] {
        PAT_BARS  = 2'd0,
        PAT_CHECK = 2'd1,
        PAT_GRAD  = 2'd2,
        PAT_BOX   = 2'd3
    } pattern_e;

    typedef logic [23:0] rgb_t;

    // One axis of the bouncing box: left/top edge plus direction (1 = increasing).
    typedef struct packed {
        logic [9:0] pos;
        logic       fwd;
    } axis_t;

    localparam rgb_t BAR_COLOURS [8] = '{
        24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
        24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
    };

    localparam rgb_t BOX_FG    = 24'hFFFFFF;
    localparam rgb_t BOX_BG    = 24'h000040;
    localparam rgb_t RGB_BLACK = 24'h000000;
    localparam rgb_t RGB_WHITE = 24'hFFFFFF;

    function automatic rgb_t bar_colour(input logic [2:0] idx);
        return BAR_COLOURS[idx];
    endfunction

endpackage

// File: rtl/pattern_gen_box_mover.sv
// Bouncing-box position tracker: one step per frame on each axis, reversing at the screen edges.
// bx/by already reflect the new frame's position during the step cycle so pixel (0,0) sees it.
module box_mover
    import hdmi_pattern_pkg::*;
#(
    parameter int BOX_SIZE  = 64,
    parameter int BOX_SPEED = 2
) (
    input  logic       clk_pix,
    input  logic       rst_in,
    input  logic       step,
    input  logic [9:0] screen_width,
    input  logic [9:0] screen_height,
    output logic [9:0] bx,
    output logic [9:0] by
);

    localparam logic [10:0] SIZE11  = 11'(BOX_SIZE);
    localparam logic [10:0] SPEED11 = 11'(BOX_SPEED);

    axis_t x_q, y_q;
    axis_t x_nxt, y_nxt;

    // 11-bit arithmetic keeps pos+size+speed from wrapping near the 10-bit limit.
    function automatic axis_t axis_step(input axis_t cur, input logic [9:0] lim);
        axis_t       nxt;
        logic [10:0] pos11;
        logic [10:0] lim11;
        nxt   = cur;
        pos11 = {1'b0, cur.pos};
        lim11 = {1'b0, lim};
        if (lim11 < SIZE11) begin
            nxt.pos = '0;
        end else if (cur.fwd) begin
            if (pos11 + SIZE11 + SPEED11 > lim11) begin
                nxt.pos = 10'(lim11 - SIZE11);
                nxt.fwd = 1'b0;
            end else begin
                nxt.pos = 10'(pos11 + SPEED11);
            end
        end else begin
            if (pos11 < SPEED11) begin
                nxt.pos = '0;
                nxt.fwd = 1'b1;
            end else begin
                nxt.pos = 10'(pos11 - SPEED11);
            end
        end
        return nxt;
    endfunction

    always_comb begin
        x_nxt = axis_step(x_q, screen_width);
        y_nxt = axis_step(y_q, screen_height);
    end

    always_ff @(posedge clk_pix) begin
        if (rst_in) begin
            x_q <= '{pos: 10'd0, fwd: 1'b1};
            y_q <= '{pos: 10'd0, fwd: 1'b1};
        end else if (step) begin
            x_q <= x_nxt;
            y_q <= y_nxt;
        end
    end

    assign bx = step ? x_nxt.pos : x_q.pos;
    assign by = step ? y_nxt.pos : y_q.pos;

endmodule

// File: rtl/pattern_gen.sv
// Test-pattern video source for the HDMI core: maps raster position to a registered 24-bit colour.
// Pattern selection and box position only change at the frame boundary, so a frame never tears.
module pattern_gen
    import hdmi_pattern_pkg::*;
#(
    parameter int BAR_W      = 80,
    parameter int CHECK_LOG2 = 5,
    parameter int BOX_SIZE   = 64,
    parameter int BOX_SPEED  = 2
) (
    input  logic        clk_pix,
    input  logic        rst_in,
    input  logic [9:0]  cx,
    input  logic [9:0]  cy,
    input  logic [9:0]  screen_start_x,
    input  logic [9:0]  screen_start_y,
    input  logic [9:0]  screen_width,
    input  logic [9:0]  screen_height,
    input  logic [1:0]  pattern_sel,
    output logic [23:0] rgb,
    output logic        frame_start,
    output logic [7:0]  frame_count
);

    if (BAR_W < 1 || BOX_SIZE < 1 || BOX_SIZE > 1023 || BOX_SPEED < 1 ||
        CHECK_LOG2 < 0 || CHECK_LOG2 > 9) begin : g_param_check
        $error("pattern_gen: BAR_W/BOX_SIZE/BOX_SPEED must be >= 1, BOX_SIZE <= 1023, CHECK_LOG2 <= 9");
    end

    localparam int          RW         = (BAR_W > 1) ? $clog2(BAR_W) : 1;
    localparam logic [RW-1:0] BAR_RELOAD = RW'(BAR_W - 1);
    localparam logic [10:0] SIZE11     = 11'(BOX_SIZE);

    logic       frame_edge;
    logic       in_x;
    logic       active;
    logic [9:0] ax;
    logic [9:0] ay;
    logic [9:0] bx;
    logic [9:0] by;
    logic       in_box;

    pattern_e   pat_q;
    pattern_e   pat_cur;
    rgb_t       pix_rgb;

    logic [RW-1:0] bar_rem_q;
    logic [RW-1:0] bar_rem_cur;
    logic [2:0]    bar_idx_q;
    logic [2:0]    bar_idx_cur;

    assign frame_edge = (cx == 10'd0) && (cy == 10'd0);
    assign in_x       = (cx >= screen_start_x);
    assign active     = in_x && (cy >= screen_start_y);
    assign ax         = cx - screen_start_x;
    assign ay         = cy - screen_start_y;
    assign pat_cur    = frame_edge ? pattern_e'(pattern_sel) : pat_q;

    box_mover #(
        .BOX_SIZE  (BOX_SIZE),
        .BOX_SPEED (BOX_SPEED)
    ) u_box_mover (
        .clk_pix       (clk_pix),
        .rst_in        (rst_in),
        .step          (frame_edge),
        .screen_width  (screen_width),
        .screen_height (screen_height),
        .bx            (bx),
        .by            (by)
    );

    // Bar index for the current pixel: down-counter of pixels left in the bar,
    // reloaded at the first active column and on each terminal count.
    always_comb begin
        bar_rem_cur = bar_rem_q;
        bar_idx_cur = bar_idx_q;
        if (cx == screen_start_x) begin
            bar_rem_cur = BAR_RELOAD;
            bar_idx_cur = 3'd0;
        end else if (bar_rem_q == '0) begin
            bar_rem_cur = BAR_RELOAD;
            if (bar_idx_q != 3'd7) begin
                bar_idx_cur = bar_idx_q + 3'd1;
            end
        end else begin
            bar_rem_cur = bar_rem_q - RW'(1);
        end
    end

    assign in_box = ({1'b0, ax} >= {1'b0, bx}) && ({1'b0, ax} < {1'b0, bx} + SIZE11) &&
                    ({1'b0, ay} >= {1'b0, by}) && ({1'b0, ay} < {1'b0, by} + SIZE11);

    always_comb begin
        pix_rgb = RGB_BLACK;
        if (active) begin
            unique case (pat_cur)
                PAT_BARS:  pix_rgb = bar_colour(bar_idx_cur);
                PAT_CHECK: pix_rgb = (ax[CHECK_LOG2] ^ ay[CHECK_LOG2]) ? RGB_WHITE : RGB_BLACK;
                PAT_GRAD:  pix_rgb = {ax[7:0], ay[7:0], ax[8:1] ^ ay[8:1]};
                PAT_BOX:   pix_rgb = in_box ? BOX_FG : BOX_BG;
                default:   pix_rgb = RGB_BLACK;
            endcase
        end
    end

    always_ff @(posedge clk_pix) begin
        if (rst_in) begin
            bar_rem_q <= '0;
            bar_idx_q <= 3'd0;
        end else if (in_x) begin
            bar_rem_q <= bar_rem_cur;
            bar_idx_q <= bar_idx_cur;
        end
    end

    always_ff @(posedge clk_pix) begin
        if (rst_in) begin
            rgb         <= RGB_BLACK;
            frame_start <= 1'b0;
            frame_count <= 8'd0;
            pat_q       <= PAT_BARS;
        end else begin
            rgb         <= pix_rgb;
            frame_start <= frame_edge;
            if (frame_edge) begin
                frame_count <= frame_count + 8'd1;
                pat_q       <= pat_cur;
            end
        end
    end

endmodule

// File: tb/tb_pattern_gen.sv
// Bench for pattern_gen: frame-level colour model checked every cycle, plus literal pixel checks.
// Raster geometry is 800x525 with a 640x480 active window starting at (160,45).
module tb_pattern_gen;

    logic        clk_pix = 1'b0;
    logic        rst_in;
    logic [9:0]  cx, cy;
    logic [9:0]  ssx, ssy, sw, sh;
    logic [1:0]  pattern_sel;
    logic [23:0] rgb;
    logic        frame_start;
    logic [7:0]  frame_count;

    int total = 0;
    int bad   = 0;

    always #5 clk_pix = ~clk_pix;

    pattern_gen #(
        .BAR_W      (80),
        .CHECK_LOG2 (5),
        .BOX_SIZE   (64),
        .BOX_SPEED  (2)
    ) dut (
        .clk_pix        (clk_pix),
        .rst_in         (rst_in),
        .cx             (cx),
        .cy             (cy),
        .screen_start_x (ssx),
        .screen_start_y (ssy),
        .screen_width   (sw),
        .screen_height  (sh),
        .pattern_sel    (pattern_sel),
        .rgb            (rgb),
        .frame_start    (frame_start),
        .frame_count    (frame_count)
    );

    // ---------------- behavioural model ----------------
    logic [23:0] bar_tab [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                 24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
    int          m_pat, m_bx, m_by, m_fc, m_x, m_y;
    bit          m_fx, m_fy;
    logic [23:0] exp_rgb;
    logic        exp_fs;
    bit          chk_en = 1'b0;

    task automatic move_axis(inout int p, inout bit fwd, input int lim);
        if (lim < 64) p = 0;
        else if (fwd && p + 64 + 2 > lim) begin p = lim - 64; fwd = 1'b0; end
        else if (!fwd && p < 2) begin p = 0; fwd = 1'b1; end
        else if (fwd) p = p + 2;
        else p = p - 2;
    endtask

    function automatic logic [23:0] model_pix(input int x, input int y);
        int ax, ay, ix;
        if (x < int'(ssx) || y < int'(ssy)) return 24'h000000;
        ax = x - int'(ssx);
        ay = y - int'(ssy);
        case (m_pat)
            0: begin
                ix = ax / 80;
                if (ix > 7) ix = 7;
                return bar_tab[3'(ix)];
            end
            1: return ((((ax >> 5) ^ (ay >> 5)) & 1) != 0) ? 24'hFFFFFF : 24'h000000;
            2: return {8'(ax & 255), 8'(ay & 255), 8'(((ax >> 1) ^ (ay >> 1)) & 255)};
            default: return (ax >= m_bx && ax < m_bx + 64 && ay >= m_by && ay < m_by + 64)
                            ? 24'hFFFFFF : 24'h000040;
        endcase
    endfunction

    initial forever begin
        @(posedge clk_pix);
        m_x = int'(cx);
        m_y = int'(cy);
        if (rst_in) begin
            m_pat = 0; m_bx = 0; m_by = 0; m_fx = 1'b1; m_fy = 1'b1; m_fc = 0;
            exp_rgb = 24'h0; exp_fs = 1'b0;
        end else begin
            exp_fs = (m_x == 0 && m_y == 0);
            if (exp_fs) begin
                m_fc  = (m_fc + 1) % 256;
                m_pat = int'(pattern_sel);
                move_axis(m_bx, m_fx, int'(sw));
                move_axis(m_by, m_fy, int'(sh));
            end
            exp_rgb = model_pix(m_x, m_y);
        end
    end

    initial forever begin
        @(negedge clk_pix);
        if (chk_en) begin
            total++;
            if (rgb !== exp_rgb) begin
                bad++;
                $display("FAIL model_rgb (%0d,%0d) got=%h want=%h", m_x, m_y, rgb, exp_rgb);
            end
            total++;
            if (frame_start !== exp_fs) begin
                bad++;
                $display("FAIL model_frame_start (%0d,%0d) got=%b want=%b", m_x, m_y, frame_start, exp_fs);
            end
            total++;
            if (frame_count !== 8'(m_fc)) begin
                bad++;
                $display("FAIL model_frame_count (%0d,%0d) got=%0d want=%0d", m_x, m_y, frame_count, m_fc);
            end
        end
    end

    // ---------------- stimulus ----------------
    logic [23:0] line_buf [1024];
    logic [23:0] last_rgb;
    logic        last_fs;
    logic [7:0]  last_fc;
    logic        fs0;
    logic [7:0]  fc0;

    task automatic check(input string name, input logic [23:0] got, input logic [23:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic pix(input int x, input int y);
        cx = 10'(x);
        cy = 10'(y);
        @(posedge clk_pix);
        #1;
        last_rgb = rgb;
        last_fs  = frame_start;
        last_fc  = frame_count;
        @(negedge clk_pix);
    endtask

    task automatic line(input int y);
        for (int x = 0; x < 800; x++) begin
            pix(x, y);
            line_buf[x] = last_rgb;
        end
    endtask

    task automatic frame_short();
        pix(0, 0);
        fs0 = last_fs;
        fc0 = last_fc;
        pix(1, 0);
        pix(2, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation time exceeded");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_in = 1'b1; pattern_sel = 2'd0; cx = 10'd5; cy = 10'd5;
        ssx = 10'd160; ssy = 10'd45; sw = 10'd640; sh = 10'd480;
        pix(5, 5);
        chk_en = 1'b1;
        pix(6, 5);
        check("reset_rgb", last_rgb, 24'h0);
        check("reset_fs", 24'(last_fs), 24'h0);
        check("reset_fc", 24'(last_fc), 24'h0);
        rst_in = 1'b0;
        pix(7, 5);

        // colour bars
        frame_short();
        check("frame1_fs", 24'(fs0), 24'h1);
        check("frame1_fc", 24'(fc0), 24'd1);
        line(45);
        check("bars_cx159", line_buf[159], 24'h000000);
        check("bars_ax0",   line_buf[160], 24'hFFFFFF);
        check("bars_ax79",  line_buf[239], 24'hFFFFFF);
        check("bars_ax80",  line_buf[240], 24'hFFFF00);
        check("bars_ax160", line_buf[320], 24'h00FFFF);
        check("bars_ax480", line_buf[640], 24'h0000FF);
        check("bars_ax639", line_buf[799], 24'h000000);

        // checker
        pattern_sel = 2'd1;
        frame_short();
        line(45);
        check("chk_0_0",  line_buf[160], 24'h000000);
        check("chk_32_0", line_buf[192], 24'hFFFFFF);
        line(77);
        check("chk_32_32", line_buf[192], 24'h000000);

        // gradient
        pattern_sel = 2'd2;
        frame_short();
        line(48);
        check("grad_5_3", line_buf[165], 24'h050303);

        // box, then a mid-frame change of pattern_sel must wait for the next frame
        pattern_sel = 2'd3;
        frame_short();
        line(45);
        check("box_bg_32_0", line_buf[192], 24'h000040);
        pattern_sel = 2'd1;
        line(45);
        check("hold_box_32_0", line_buf[192], 24'h000040);
        pix(0, 0);
        check("switch_fs", 24'(last_fs), 24'h1);
        check("switch_fc", 24'(last_fc), 24'd5);
        pix(1, 0);
        line(45);
        check("switch_chk_32_0", line_buf[192], 24'hFFFFFF);

        // reset in the middle of a line
        pattern_sel = 2'd3;
        for (int x = 0; x <= 300; x++) pix(x, 50);
        rst_in = 1'b1;
        pix(301, 50);
        check("midrst_rgb", last_rgb, 24'h0);
        check("midrst_fc", 24'(last_fc), 24'd0);
        check("midrst_fs", 24'(last_fs), 24'h0);
        rst_in = 1'b0;

        frame_short();
        check("rst_frame1_fc", 24'(fc0), 24'd1);
        line(47);
        check("box22_ax1",  line_buf[161], 24'h000040);
        check("box22_ax2",  line_buf[162], 24'hFFFFFF);
        check("box22_ax65", line_buf[225], 24'hFFFFFF);
        check("box22_ax66", line_buf[226], 24'h000040);
        line(46);
        check("box22_ay1", line_buf[162], 24'h000040);

        repeat (254) frame_short();
        check("fc_255", 24'(fc0), 24'd255);
        frame_short();
        check("fc_wrap", 24'(fc0), 24'd0);

        repeat (31) frame_short();
        line(305);
        check("bx574_ax573", line_buf[733], 24'h000040);
        check("bx574_ax574", line_buf[734], 24'hFFFFFF);

        frame_short();
        line(303);
        check("bx576_ax575", line_buf[735], 24'h000040);
        check("bx576_ax576", line_buf[736], 24'hFFFFFF);
        check("bx576_ax639", line_buf[799], 24'hFFFFFF);

        frame_short();
        line(301);
        check("flip_ax575", line_buf[735], 24'h000040);
        check("flip_ax576", line_buf[736], 24'hFFFFFF);

        frame_short();
        line(299);
        check("back_ax573", line_buf[733], 24'h000040);
        check("back_ax574", line_buf[734], 24'hFFFFFF);
        check("back_ax637", line_buf[797], 24'hFFFFFF);
        check("back_ax638", line_buf[798], 24'h000040);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
